// File: rtl/pa_fadd_lop_ctrl_pkg.sv
// pa_fadd_lop_ctrl_pkg: shared FALU constants for the close-path
// LOP sequencer (datapath widths and FSM state encoding).
package pa_fadd_lop_ctrl_pkg;

    localparam int FADD_LOP_W   = 28;
    localparam int FADD_SHAMT_W = 5;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_PRED  = 3'd1;
    localparam logic [ST_W-1:0] ST_SHIFT = 3'd2;
    localparam logic [ST_W-1:0] ST_FIX   = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/pa_fadd_lop_ctrl_if.sv
// pa_fadd_lop_ctrl_if: request, LOP and response bundle between the
// requesters/LOP (master side) and the sequencer (slave side).
interface pa_fadd_lop_ctrl_if;
    import pa_fadd_lop_ctrl_pkg::*;

    logic                    req0_vld;
    logic                    req1_vld;
    logic [FADD_LOP_W-1:0]   req0_src0;
    logic [FADD_LOP_W-1:0]   req0_src1;
    logic [FADD_LOP_W-1:0]   req1_src0;
    logic [FADD_LOP_W-1:0]   req1_src1;
    logic [FADD_LOP_W-1:0]   req0_mask;
    logic [FADD_LOP_W-1:0]   req1_mask;
    logic                    req0_rdy;
    logic                    req1_rdy;

    logic [FADD_LOP_W-1:0]   lop_src0;
    logic [FADD_LOP_W-1:0]   lop_src1;
    logic [FADD_LOP_W-1:0]   lop_mask;
    logic [FADD_SHAMT_W-1:0] lop_pred;
    logic [FADD_LOP_W-1:0]   lop_pred_onehot;

    logic                    rsp_vld;
    logic                    rsp_rdy;
    logic                    rsp_id;
    logic [FADD_LOP_W-1:0]   rsp_data;
    logic [FADD_SHAMT_W-1:0] rsp_shamt;
    logic                    rsp_zero;

    modport slave (
        input  req0_vld, req1_vld,
        input  req0_src0, req0_src1, req0_mask,
        input  req1_src0, req1_src1, req1_mask,
        output req0_rdy, req1_rdy,
        output lop_src0, lop_src1, lop_mask,
        input  lop_pred, lop_pred_onehot,
        output rsp_vld, rsp_id, rsp_data, rsp_shamt, rsp_zero,
        input  rsp_rdy
    );

    modport master (
        output req0_vld, req1_vld,
        output req0_src0, req0_src1, req0_mask,
        output req1_src0, req1_src1, req1_mask,
        input  req0_rdy, req1_rdy,
        input  lop_src0, lop_src1, lop_mask,
        output lop_pred, lop_pred_onehot,
        input  rsp_vld, rsp_id, rsp_data, rsp_shamt, rsp_zero,
        output rsp_rdy
    );

endinterface

// File: rtl/pa_fadd_lop_rr_arb.sv
// pa_fadd_lop_rr_arb: 2-way round-robin grant; the pointer holds the
// last granted requester and resets to 1 so requester 0 wins first.
module pa_fadd_lop_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] vld_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    // Grant the requester not served last when both are valid.
    always_comb begin
        gnt_o[0] = en_i & vld_i[0] & (~vld_i[1] | last_q);
        gnt_o[1] = en_i & vld_i[1] & (~vld_i[0] | ~last_q);
        last_d   = last_q;
        if (gnt_o[1]) begin
            last_d = 1'b1;
        end else if (gnt_o[0]) begin
            last_d = 1'b0;
        end
    end

    // Last-grant pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/pa_fadd_lop_ctrl.sv
// pa_fadd_lop_ctrl: arbitrates FADD/FCVT requests onto the shared LOP,
// normalizes the difference and corrects one-bit LOP under-prediction.
module pa_fadd_lop_ctrl
    import pa_fadd_lop_ctrl_pkg::*;
(
    input  logic               cpuclk,
    input  logic               cpurst_b,
    input  logic               ctrl_flush,
    pa_fadd_lop_ctrl_if.slave  bus
);

    logic [ST_W-1:0]         state_q;
    logic [ST_W-1:0]         state_d;
    logic [1:0]              gnt;
    logic                    arb_en;
    logic                    hs;

    logic [FADD_LOP_W-1:0]   src0_q;
    logic [FADD_LOP_W-1:0]   src1_q;
    logic [FADD_LOP_W-1:0]   mask_q;
    logic                    id_q;

    logic [FADD_LOP_W-1:0]   diff_q;
    logic [FADD_SHAMT_W-1:0] pred_q;
    logic                    lim_q;
    logic [FADD_LOP_W-1:0]   sh;
    logic                    diff_zero;

    logic [FADD_LOP_W-1:0]   rsp_data_q;
    logic [FADD_LOP_W-1:0]   rsp_data_d;
    logic [FADD_SHAMT_W-1:0] rsp_shamt_q;
    logic [FADD_SHAMT_W-1:0] rsp_shamt_d;
    logic                    rsp_zero_q;
    logic                    rsp_zero_d;
    logic                    rsp_id_q;
    logic                    rsp_id_d;

    assign arb_en = (state_q == ST_IDLE) & ~ctrl_flush;
    assign hs     = |gnt;

    pa_fadd_lop_rr_arb u_arb (
        .clk   (cpuclk),
        .rst_n (cpurst_b),
        .en_i  (arb_en),
        .vld_i ({bus.req1_vld, bus.req0_vld}),
        .gnt_o (gnt)
    );

    assign bus.req0_rdy  = gnt[0];
    assign bus.req1_rdy  = gnt[1];

    assign bus.lop_src0  = src0_q;
    assign bus.lop_src1  = src1_q;
    assign bus.lop_mask  = mask_q;

    assign bus.rsp_vld   = (state_q == ST_DONE);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_shamt = rsp_shamt_q;
    assign bus.rsp_zero  = rsp_zero_q;

    assign sh        = diff_q << pred_q;
    assign diff_zero = (diff_q == '0);

    // Sequencer next state; flush overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (hs) state_d = ST_PRED;
            ST_PRED:  state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (diff_zero || sh[FADD_LOP_W-1] || lim_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:   state_d = ST_DONE;
            ST_DONE:  if (bus.rsp_rdy) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (ctrl_flush) begin
            state_d = ST_IDLE;
        end
    end

    // Response fields: first-pass shift result, then the one-bit fix.
    always_comb begin
        rsp_data_d  = rsp_data_q;
        rsp_shamt_d = rsp_shamt_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_id_d    = rsp_id_q;
        if (state_q == ST_SHIFT) begin
            rsp_id_d   = id_q;
            rsp_zero_d = diff_zero;
            if (diff_zero) begin
                rsp_data_d  = '0;
                rsp_shamt_d = '0;
            end else begin
                rsp_data_d  = sh;
                rsp_shamt_d = pred_q;
            end
        end else if (state_q == ST_FIX) begin
            rsp_data_d  = sh << 1;
            rsp_shamt_d = pred_q + 5'd1;
        end
    end

    // State and response registers.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= ST_IDLE;
            rsp_data_q  <= '0;
            rsp_shamt_q <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_data_q  <= rsp_data_d;
            rsp_shamt_q <= rsp_shamt_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // Operand capture on the request handshake.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            src0_q <= '0;
            src1_q <= '0;
            mask_q <= '0;
            id_q   <= 1'b0;
        end else if (hs) begin
            src0_q <= gnt[1] ? bus.req1_src0 : bus.req0_src0;
            src1_q <= gnt[1] ? bus.req1_src1 : bus.req0_src1;
            mask_q <= gnt[1] ? bus.req1_mask : bus.req0_mask;
            id_q   <= gnt[1];
        end
    end

    // Difference and LOP prediction registered in PRED.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            diff_q <= '0;
            pred_q <= '0;
            lim_q  <= 1'b0;
        end else if (state_q == ST_PRED) begin
            diff_q <= src0_q + ~src1_q + 28'd1;
            pred_q <= bus.lop_pred;
            lim_q  <= |(bus.lop_pred_onehot & mask_q);
        end
    end

    // A FIX can only follow a one-bit under-prediction and must normalize.
    always_ff @(posedge cpuclk) begin
        if (cpurst_b && state_q == ST_FIX) begin
            assert (pred_q != 5'd27);
            assert (sh[FADD_LOP_W-2]);
        end
    end

endmodule

// File: tb/tb_pa_fadd_lop_ctrl.sv
// tb_pa_fadd_lop_ctrl: directed and random checks of the LOP sequencer
// against an arithmetic normalize model and a stub LOP.
module tb_pa_fadd_lop_ctrl;
    import pa_fadd_lop_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic under = 1'b0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;
    int   lop_lz;
    int   lop_p;
    int   lop_lim;

    pa_fadd_lop_ctrl_if bus ();

    pa_fadd_lop_ctrl dut (
        .cpuclk     (clk),
        .cpurst_b   (rst_n),
        .ctrl_flush (flush),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Leading zeros of a 28-bit value (28 when zero).
    function automatic int lz_of(input logic [27:0] d);
        for (int i = 27; i >= 0; i--) begin
            if (d[i]) return 27 - i;
        end
        return 28;
    endfunction

    // Largest shift allowed by a one-hot mask.
    function automatic int lim_of(input logic [27:0] m);
        return (m == '0) ? 27 : lz_of(m);
    endfunction

    // Stub LOP: exact leading-zero count, optionally one short.
    always_comb begin
        lop_lz  = lz_of(bus.lop_src0 - bus.lop_src1);
        lop_lim = lim_of(bus.lop_mask);
        lop_p   = (lop_lz > 27) ? 27 : lop_lz;
        if (under && lop_lz >= 1 && lop_lz <= 27) lop_p = lop_p - 1;
        if (lop_p > lop_lim) lop_p = lop_lim;
        bus.lop_pred        = 5'(lop_p);
        bus.lop_pred_onehot = 28'd1 << (27 - lop_p);
    end

    // Expected normalize result: shift by min(lead zeros, mask limit).
    function automatic void exp_model(
        input  logic [27:0] s0, input logic [27:0] s1,
        input  logic [27:0] m,  input logic und,
        output logic [27:0] ed, output logic [4:0] es,
        output logic ez, output int el);
        logic [27:0] d;
        int lz, lim, n;
        d   = s0 - s1;
        lz  = lz_of(d);
        lim = lim_of(m);
        n   = (lz < lim) ? lz : lim;
        ez  = (d == '0);
        ed  = ez ? 28'd0 : (d << n);
        es  = ez ? 5'd0 : 5'(n);
        el  = (und && !ez && lz >= 1 && lz <= lim) ? 4 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit id, input bit v, input logic [27:0] s0,
                         input logic [27:0] s1, input logic [27:0] m);
        if (id) begin
            bus.req1_vld = v; bus.req1_src0 = s0;
            bus.req1_src1 = s1; bus.req1_mask = m;
        end else begin
            bus.req0_vld = v; bus.req0_src0 = s0;
            bus.req0_src1 = s1; bus.req0_mask = m;
        end
    endtask

    // One request through to response, with hold cycles of backpressure.
    task automatic run_op(input bit id, input logic [27:0] s0,
                          input logic [27:0] s1, input logic [27:0] m,
                          input logic und, input int hold);
        logic [27:0] ed;
        logic [4:0] es;
        logic ez;
        int el, lat;
        bit got;
        exp_model(s0, s1, m, und, ed, es, ez, el);
        @(negedge clk);
        under = und;
        drive(id, 1'b1, s0, s1, m);
        #1;
        got = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            if (id ? bus.req1_rdy : bus.req0_rdy) got = 1;
            else begin @(negedge clk); #1; end
        end
        chk("accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        drive(id, 1'b0, s0, s1, m);
        lat = 0;
        while (!bus.rsp_vld && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, el);
        chk("rsp_data", bus.rsp_data, ed);
        chk("rsp_shamt", bus.rsp_shamt, es);
        chk("rsp_zero", bus.rsp_zero, ez);
        chk("rsp_id", bus.rsp_id, id);
        drive(!id, 1'b1, 28'h0000F00, 28'h0000001, '0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_vld", bus.rsp_vld, 1);
            chk("hold_data", bus.rsp_data, ed);
            chk("hold_shamt", bus.rsp_shamt, es);
            chk("hold_rdy", {bus.req1_rdy, bus.req0_rdy}, 0);
        end
        bus.rsp_rdy = 1'b1;
        #1;
        chk("exit_no_accept", {bus.req1_rdy, bus.req0_rdy}, 0);
        @(posedge clk); #1;
        bus.rsp_rdy = 1'b0;
        drive(!id, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("rsp_dropped", bus.rsp_vld, 0);
    endtask

    // Continuous requests with rsp_rdy high; record grants and ids.
    task automatic arb_run(input bit both);
        int gid[$];
        int gcyc[$];
        int pend[$];
        int e;
        @(negedge clk);
        bus.rsp_rdy = 1'b1;
        under = 1'b0;
        drive(0, 1'b1, 28'h8000000, 28'h7FFFFFF, '0);
        drive(1, both, 28'h8000000, 28'h7FFFFFF, '0);
        #1;
        for (int c = 0; c < 16; c++) begin
            if (bus.req0_rdy) begin
                gid.push_back(0); gcyc.push_back(c); pend.push_back(0);
            end
            if (bus.req1_rdy) begin
                gid.push_back(1); gcyc.push_back(c); pend.push_back(1);
            end
            if (bus.rsp_vld) begin
                e = (pend.size() == 0) ? 2 : pend.pop_front();
                chk("arb_rsp_id", bus.rsp_id, e);
            end
            @(negedge clk); #1;
        end
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        bus.rsp_rdy = 1'b0;
        chk("arb_ngrants", gid.size(), 4);
        for (int k = 0; k < gid.size(); k++) begin
            chk("arb_gnt_id", gid[k], both ? (k % 2) : 0);
            chk("arb_gnt_cyc", gcyc[k], 4 * k);
        end
    endtask

    initial begin
        logic [27:0] d, s1, m;
        int lat;
        bus.rsp_rdy = 1'b0;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        chk("rst_vld", bus.rsp_vld, 0);
        chk("rst_data", bus.rsp_data, 0);
        chk("rst_id", bus.rsp_id, 0);
        chk("rst_lop_src0", bus.lop_src0, 0);
        rst_n = 1'b1;

        run_op(0, 28'h8000000, 28'h7FFFFFF, '0, 1'b0, 5);
        run_op(1, 28'h4000000, 28'h0000001, '0, 1'b1, 0);
        run_op(0, 28'h1234567, 28'h1234567, '0, 1'b0, 1);

        // Flush while in SHIFT.
        @(negedge clk);
        under = 1'b0;
        drive(0, 1'b1, 28'h5555555, 28'h1111111, '0);
        #1;
        chk("fl_accept", bus.req0_rdy, 1);
        @(posedge clk); #1;
        drive(0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        flush = 1'b1;
        drive(1, 1'b1, 28'h0000100, 28'h0, '0);
        @(posedge clk); #1;
        chk("fl_rdy_blocked", bus.req1_rdy, 0);
        drive(1, 1'b0, '0, '0, '0);
        flush = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("fl_no_rsp", bus.rsp_vld, 0);
        end

        // Flush together with rsp_rdy in DONE.
        @(negedge clk);
        drive(0, 1'b1, 28'h0F00000, 28'h0000001, '0);
        @(posedge clk); #1;
        drive(0, 1'b0, '0, '0, '0);
        lat = 0;
        while (!bus.rsp_vld && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("fd_vld", bus.rsp_vld, 1);
        flush = 1'b1;
        bus.rsp_rdy = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.rsp_rdy = 1'b0;
        @(negedge clk);
        chk("fd_idle", bus.rsp_vld, 0);

        for (int r = 0; r < 24; r++) begin
            d = 28'($urandom) >> $urandom_range(0, 27);
            if ($urandom_range(0, 7) == 0) d = '0;
            s1 = 28'($urandom_range(0, 32'h0FFFFFFF - 32'(d)));
            m = '0;
            if ($urandom_range(0, 1) == 1) begin
                m = 28'd1 << $urandom_range(0, 27);
            end
            run_op(1'($urandom_range(0, 1)), s1 + d, s1, m,
                   1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        run_op(1, 28'h0000100, 28'h0000000, 28'h0800000, 1'b1, 0);

        // Asynchronous reset in PRED.
        @(negedge clk);
        under = 1'b0;
        drive(0, 1'b1, 28'h0ABCDEF, 28'h0000123, '0);
        #1;
        chk("rs_accept", bus.req0_rdy, 1);
        @(posedge clk); #1;
        drive(0, 1'b0, '0, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_vld", bus.rsp_vld, 0);
        chk("rs_data", bus.rsp_data, 0);
        chk("rs_shamt", bus.rsp_shamt, 0);
        chk("rs_zero", bus.rsp_zero, 0);
        chk("rs_id", bus.rsp_id, 0);
        chk("rs_lop_src0", bus.lop_src0, 0);
        chk("rs_lop_src1", bus.lop_src1, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rs_no_rsp", bus.rsp_vld, 0);
        end
        rst_n = 1'b1;

        arb_run(1'b1);
        arb_run(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
